// File: rtl/onehot_pkg.sv
// Shared widths, FSM state type and index-to-line helper for the one-hot pulse decoder.
package onehot_pkg;

  localparam int IDX_W = 3;
  localparam int OUT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_e;

  function automatic logic [OUT_W-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [OUT_W-1:0] line;
    line = '0;
    line[idx] = 1'b1;
    return line;
  endfunction

endpackage

// File: rtl/onehot_req_fifo.sv
// Show-ahead synchronous FIFO; flush empties it, rst also returns both pointers to zero.
module onehot_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;

  // Extra pointer bit distinguishes a wrapped (full) FIFO from an empty one.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push && !full) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push && !full) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/onehot_pulse_decoder.sv
// Buffers line indices and drives each as a one-hot pulse of in_hold+1 cycles,
// followed by a one-cycle all-zero gap flagged by done.
module onehot_pulse_decoder
  import onehot_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic [HOLD_W-1:0] in_hold,
  output logic [OUT_W-1:0]  onehot,
  output logic              busy,
  output logic              done
);

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [HOLD_W-1:0] hold;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  req_t             wr_req, head_req;
  logic [REQ_W-1:0] head_bits;
  logic             full, empty, push, pop;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0]  onehot_q, onehot_d;
  logic              done_q, done_d;

  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;
  assign wr_req   = '{idx: in_idx, hold: in_hold};
  assign head_req = req_t'(head_bits);

  onehot_req_fifo #(.DEPTH(DEPTH), .W(REQ_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .wdata (wr_req),
    .pop   (pop),
    .head  (head_bits),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    onehot_d = onehot_q;
    done_d   = 1'b0;
    pop      = 1'b0;
    unique case (state_q)
      IDLE, GAP: begin
        onehot_d = '0;
        state_d  = IDLE;
        if (!empty) begin
          pop      = 1'b1;
          cnt_d    = head_req.hold;
          onehot_d = idx_to_onehot(head_req.idx);
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          onehot_d = '0;
          done_d   = 1'b1;
          state_d  = GAP;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort drops the pulse in flight and suppresses its done.
    if (flush) begin
      state_d  = IDLE;
      onehot_d = '0;
      done_d   = 1'b0;
      pop      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      onehot_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
      done_q   <= done_d;
    end
  end

  assign onehot = onehot_q;
  assign done   = done_q;
  assign busy   = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Directed checks of the one-hot pulse decoder; outputs sampled 1ns after each rising edge.
module tb_onehot_pulse_decoder;

  localparam int DEPTH  = 4;
  localparam int HOLD_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        in_idx = '0;
  logic [HOLD_W-1:0] in_hold = '0;
  logic [7:0]        onehot;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onehot_pulse_decoder #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_idx   (in_idx),
    .in_hold  (in_hold),
    .onehot   (onehot),
    .busy     (busy),
    .done     (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-24s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference priority encoder: index of the highest set line.
  function automatic int prio_enc(input logic [7:0] v);
    int r;
    r = -1;
    for (int k = 0; k < 8; k++) if (v[k]) r = k;
    return r;
  endfunction

  task automatic push(input logic [2:0] idx, input logic [HOLD_W-1:0] hold);
    in_valid = 1'b1;
    in_idx   = idx;
    in_hold  = hold;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int order [$];
    logic [7:0] prev;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check("rst_onehot", onehot, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);

    // Single request idx=5 hold=2
    push(3'd5, 4'd2);
    check("single_E_onehot", onehot, 8'h00);
    check("single_E_busy", busy, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      tick();
      check($sformatf("single_drive%0d", c), onehot, 8'h20);
    end
    tick();
    check("single_gap_onehot", onehot, 8'h00);
    check("single_gap_done", done, 1'b1);
    tick();
    check("single_idle_done", done, 1'b0);
    check("single_idle_busy", busy, 1'b0);

    // Reset in the 3rd drive cycle of idx=6 hold=7
    push(3'd6, 4'd7);
    tick();
    tick();
    tick();
    check("rstmid_drive3", onehot, 8'h40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_onehot", onehot, 8'h00);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_done", done, 1'b0);
    push(3'd1, 4'd0);
    tick();
    check("rstmid_latency", onehot, 8'h02);
    tick();
    check("rstmid_gap_done", done, 1'b1);
    tick();

    // Back-to-back: idx0/hold0 then idx7/hold1
    in_valid = 1'b1; in_idx = 3'd0; in_hold = 4'd0;
    tick();
    in_idx = 3'd7; in_hold = 4'd1;
    tick();
    in_valid = 1'b0;
    check("b2b_first", onehot, 8'h01);
    tick();
    check("b2b_gap1_onehot", onehot, 8'h00);
    check("b2b_gap1_done", done, 1'b1);
    tick();
    check("b2b_second_c1", onehot, 8'h80);
    check("b2b_second_done", done, 1'b0);
    tick();
    check("b2b_second_c2", onehot, 8'h80);
    tick();
    check("b2b_gap2_onehot", onehot, 8'h00);
    check("b2b_gap2_done", done, 1'b1);
    tick();
    check("b2b_idle_busy", busy, 1'b0);

    // Full: idx2/hold15 goes straight to DRIVE, idx3..6 fill the FIFO, idx7 waits
    in_valid = 1'b1; in_idx = 3'd2; in_hold = 4'd15;
    tick();
    for (int i = 3; i <= 6; i++) begin
      in_idx = 3'(i); in_hold = 4'd0;
      tick();
    end
    in_idx = 3'd7; in_hold = 4'd0;
    check("full_in_ready_low", in_ready, 1'b0);
    check("full_long_pulse", onehot, 8'h04);
    for (int c = 0; c < 13; c++) tick();
    check("full_gap_done", done, 1'b1);
    check("full_gap_in_ready", in_ready, 1'b0);
    tick();
    check("full_after_pop_ready", in_ready, 1'b1);
    prev = 8'h00;
    for (int c = 0; c < 14; c++) begin
      if (onehot != 8'h00 && prev == 8'h00) order.push_back(prio_enc(onehot));
      prev = onehot;
      tick();
      if (c == 0) in_valid = 1'b0;
    end
    check("full_pulse_count", order.size(), 5);
    for (int i = 0; i < order.size() && i < 5; i++)
      check($sformatf("full_order%0d", i), order[i], i + 3);
    check("full_end_busy", busy, 1'b0);

    // Flush during DRIVE with two queued requests
    push(3'd1, 4'd5);
    in_valid = 1'b1; in_idx = 3'd2; in_hold = 4'd0;
    tick();
    check("flush_driving", onehot, 8'h02);
    in_idx = 3'd3;
    tick();
    in_idx = 3'd4;
    flush = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 1'b0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_onehot", onehot, 8'h00);
    check("flush_done", done, 1'b0);
    check("flush_busy", busy, 1'b0);
    tick();
    check("flush_after_onehot", onehot, 8'h00);
    check("flush_after_done", done, 1'b0);
    check("flush_after_busy", busy, 1'b0);

    // Sweep every index with hold=0
    for (int i = 0; i < 8; i++) begin
      push(3'(i), 4'd0);
      tick();
      check($sformatf("sweep%0d_onehot", i), onehot, 32'h1 << i);
      check($sformatf("sweep%0d_ones", i), $countones(onehot), 1);
      check($sformatf("sweep%0d_enc", i), prio_enc(onehot), i);
      tick();
      check($sformatf("sweep%0d_done", i), done, 1'b1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
